pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
Multi-channel PWM generator. It is the parametrised successor of the single-channel pwm block.
- One shared period counter drives CHANNELS independent duty comparators.
- Period and duty values are double-buffered. A new setting takes effect only at a period boundary, so no glitches or runt pulses occur.
- Supports edge-aligned and center-aligned modes, plus per-channel output polarity.
- Sits between the register/config logic and the motor/LED driver pins.

Parameters:
WIDTH, 16, bit width of period, duty and counter
CHANNELS, 4, number of PWM outputs sharing one timebase

Ports:
clk  in  1  system clock (50 MHz nominal)
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = run counter; 0 = hold counter at 0, outputs at inactive level
center_mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled only at period boundary or while disabled
period  in  WIDTH  period in clk cycles (edge mode) or half-period (center mode)
duty  in  CHANNELS*WIDTH  per-channel compare values, channel i at bits [i*WIDTH +: WIDTH]
load  in  1  one-cycle strobe; captures period, duty and center_mode into staging registers
polarity  in  CHANNELS  per-channel: 0 = active-high, 1 = inverted
pwm_out  out  CHANNELS  registered PWM outputs
period_end  out  1  one-cycle pulse marking the first output cycle of each new period
load_pending  out  1  high while staged values are waiting for a boundary

Behaviour:
Reset:
- Reset is asynchronous and active-low, and takes effect immediately.
- Counter = 0, direction = up.
- Active and staging registers = 0.
- pwm_out = 0, period_end = 0, load_pending = 0.

Staging and apply:
- load copies the inputs into staging and sets load_pending.
- Multiple loads before a boundary: the last one wins.
- At a boundary, staging is copied into the active registers and load_pending clears.
- load in the same cycle as a boundary: the new inputs are applied at that boundary directly; load_pending stays 0.
- While enable = 0: load applies to the active registers on the next clk; load_pending never sets.

Edge mode:
- Counter runs 0..P-1, then wraps to 0. The wrap is the boundary.
- Raw output for channel i = (cnt < D_i).

Center mode:
- Counter counts up 0..P-1, then down P-1..0. Both ends repeat once, giving 2P cycles per period.
- Boundary = the cycle after the down count reaches 0.
- Raw output = (cnt < D_i). High time = 2*D_i cycles, centered on the boundary.

Boundary cases:
- D_i = 0: output constantly inactive.
- D_i >= P: output constantly active.
- P = 0: counter held at 0, all outputs inactive, period_end never pulses, staged values are still applied every cycle.
- P = 1, edge mode: a boundary occurs every cycle.

Output timing and enable:
- pwm_out[i] = registered (raw XOR polarity[i]), one cycle of latency after the counter value.
- period_end is registered and aligned with the first pwm_out sample of a period.
- enable 1->0: on the next clk, counter = 0, direction = up, pwm_out = polarity, period_end = 0.
- enable 0->1: counting starts from 0. The first pwm_out sample appears one cycle later, together with a period_end pulse.
- Arithmetic: counter is unsigned WIDTH bits; comparisons are unsigned; no overflow is possible because cnt <= P-1.

Decomposition:
Package pwm_pkg:
- pwm_mode_e enum (PWM_EDGE, PWM_CENTER).
- PWM_WIDTH_DEFAULT = 16, PWM_CHANNELS_DEFAULT = 4.

Sub-module pwm_channel_cmp (one generate instance per channel):
- Holds the active duty register, the compare, the polarity XOR and the output flop.
- Inputs: clk, rst_n, enable, cnt, apply, duty_stage, polarity.

The top level keeps the counter, direction, staging registers and boundary/pending logic.

Test Plan:
1. Edge mode, P=10000, D={2500, 5000, 7500, 0}, polarity=0, enable=1 -> per 10000-cycle period, ch0/1/2 high 2500/5000/7500 cycles starting at period_end; ch3 always 0; period_end every 10000 cycles.
2. Limit values: D0=P=200, D1=65535, D2=0; then P=0 -> ch0/ch1 constant 1 and ch2 constant 0; with P=0 all outputs 0 and no period_end pulses.
3. Mid-period reload: P=10000, D0=2500; load D0=5000 at cnt=3000 -> current period high 2500 cycles; load_pending=1 until the next period_end; next period high 5000 cycles. A second load (D0=7000) before the boundary -> 7000 is applied, not 5000.
4. Center mode, P=100, D0=25 -> period 200 cycles; ch0 high 50 consecutive cycles (25 before the boundary and 25 after); period_end every 200 cycles.
5. polarity=4'b0001, D0=2500, P=10000 -> ch0 low 2500 / high 7500 cycles. Drop enable -> ch0=1 and others 0 on the next clk, counter returns to 0. Raise enable -> restart with period_end one cycle later.
6. Assert rst_n=0 asynchronously while ch0 is high and load_pending=1 -> pwm_out=0, load_pending=0 and period_end=0 immediately, without waiting for clk. After release with enable=1 and P=0 (reset value) -> outputs stay 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  localparam int PWM_WIDTH_DEFAULT    = 16;
  localparam int PWM_CHANNELS_DEFAULT = 4;

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: active duty register, compare against the shared counter,
// polarity inversion and the registered output.
module pwm_channel_cmp
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] cnt,
  input  logic             apply,
  input  logic [WIDTH-1:0] duty_stage,
  input  logic             polarity,
  output logic             pwm
);

  logic [WIDTH-1:0] duty_q;
  logic             raw;

  assign raw = (cnt < duty_q);

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
    end else if (apply) begin
      duty_q <= duty_stage;
    end
  end

  // While not running, the pin sits at its inactive level for this polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else begin
      pwm <= enable ? (raw ^ polarity) : polarity;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared edge/center-aligned timebase, double-buffered
// period/duty/mode applied only at period boundaries.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH_DEFAULT,
  parameter int CHANNELS = PWM_CHANNELS_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      center_mode,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      load,
  input  logic [CHANNELS-1:0]       polarity,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_end,
  output logic                      load_pending
);

  logic [WIDTH-1:0]          cnt, cnt_next;
  logic                      dir_down, dir_next;
  logic [WIDTH-1:0]          period_act, period_stage, period_next, period_last;
  pwm_mode_e                 mode_act, mode_stage, mode_next;
  logic [CHANNELS*WIDTH-1:0] duty_stage_q, duty_next;
  logic                      run, wrap, apply;

  assign run         = enable && (period_act != '0);
  assign period_last = period_act - WIDTH'(1);

  // A load coinciding with an apply bypasses staging so it lands this boundary.
  assign period_next = load ? period : period_stage;
  assign mode_next   = load ? pwm_mode_e'(center_mode) : mode_stage;
  assign duty_next   = load ? duty : duty_stage_q;

  always_comb begin
    wrap = 1'b0;
    if (run) begin
      if (mode_act == PWM_EDGE) wrap = (cnt >= period_last);
      else                      wrap = dir_down && (cnt == '0);
    end
  end

  // Disabled or zero period counts as a boundary every cycle.
  assign apply = !run || wrap;

  always_comb begin
    cnt_next = '0;
    dir_next = 1'b0;
    if (run) begin
      if (mode_act == PWM_EDGE) begin
        cnt_next = wrap ? '0 : cnt + WIDTH'(1);
      end else if (!dir_down) begin
        if (cnt >= period_last) begin
          cnt_next = cnt;
          dir_next = 1'b1;
        end else begin
          cnt_next = cnt + WIDTH'(1);
        end
      end else if (cnt != '0) begin
        cnt_next = cnt - WIDTH'(1);
        dir_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dir_down <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      dir_down <= dir_next;
    end
  end

  // NOTE: staging and active settings are real control state, not storage
  // arrays, so they are reset to give a known quiet configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_stage <= '0;
      duty_stage_q <= '0;
      mode_stage   <= PWM_EDGE;
      period_act   <= '0;
      mode_act     <= PWM_EDGE;
      load_pending <= 1'b0;
    end else begin
      if (load) begin
        period_stage <= period;
        duty_stage_q <= duty;
        mode_stage   <= pwm_mode_e'(center_mode);
      end
      if (apply) begin
        period_act <= period_next;
        mode_act   <= mode_next;
      end
      load_pending <= apply ? 1'b0 : (load_pending || load);
    end
  end

  // Period start is the up-counting zero; the down zero ends a center period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_end <= 1'b0;
    end else begin
      period_end <= run && (cnt == '0) && !dir_down;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel_cmp #(
      .WIDTH(WIDTH)
    ) u_cmp (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (run),
      .cnt       (cnt),
      .apply     (apply),
      .duty_stage(duty_next[i*WIDTH +: WIDTH]),
      .polarity  (polarity[i]),
      .pwm       (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: expected per-period records are queued when
// a setting is driven and compared as each measured period completes.
module tb_pwm_multi;

  localparam int W  = 16;
  localparam int CH = 4;

  typedef struct packed {
    logic [31:0]          len;
    logic [CH-1:0][31:0]  hi;
    logic [CH-1:0]        first;
    logic [CH-1:0]        last;
  } rec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              center_mode;
  logic [W-1:0]      period;
  logic [CH*W-1:0]   duty;
  logic              load;
  logic [CH-1:0]     polarity;
  logic [CH-1:0]     pwm_out;
  logic              period_end;
  logic              load_pending;

  rec_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   restart_req = 0;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .center_mode (center_mode),
    .period      (period),
    .duty        (duty),
    .load        (load),
    .polarity    (polarity),
    .pwm_out     (pwm_out),
    .period_end  (period_end),
    .load_pending(load_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [CH*W-1:0] pack(input int d0, input int d1, input int d2, input int d3);
    return {W'(d3), W'(d2), W'(d1), W'(d0)};
  endfunction

  // Expected high time and first/last samples of one period, from the duty/period definition.
  function automatic rec_t model(input int p, input logic [CH*W-1:0] dv, input bit center,
                                 input logic [CH-1:0] pol);
    rec_t r;
    int   d, h;
    r.len = center ? 2 * p : p;
    for (int c = 0; c < CH; c++) begin
      d = int'(dv[c*W +: W]);
      h = (d < p) ? d : p;
      if (center) h = 2 * h;
      r.first[c] = (d > 0);
      r.last[c]  = center ? (d > 0) : (d >= p);
      if (pol[c]) begin
        h          = r.len - h;
        r.first[c] = ~r.first[c];
        r.last[c]  = ~r.last[c];
      end
      r.hi[c] = h;
    end
    return r;
  endfunction

  // Monitor: samples 1 time unit after each rising edge, one record per period_end interval.
  initial begin
    int            len;
    int            hi[CH];
    logic [CH-1:0] first, last;
    bit            in_rec;
    int            seen;
    rec_t          e;
    in_rec = 0;
    seen   = 0;
    len    = 0;
    first  = '0;
    last   = '0;
    for (int c = 0; c < CH; c++) hi[c] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (seen != restart_req) begin
        seen   = restart_req;
        in_rec = 0;
      end
      if (!rst_n) begin
        in_rec = 0;
      end else begin
        if (period_end) begin
          if (in_rec && sb.size() > 0) begin
            e = sb.pop_front();
            check("per_len", len, e.len);
            for (int c = 0; c < CH; c++) check($sformatf("per_hi%0d", c), hi[c], e.hi[c]);
            check("per_first", first, e.first);
            check("per_last", last, e.last);
          end
          in_rec = 1;
          len    = 0;
          first  = pwm_out;
          for (int c = 0; c < CH; c++) hi[c] = 0;
        end
        if (in_rec) begin
          len++;
          for (int c = 0; c < CH; c++) hi[c] += int'(pwm_out[c]);
          last = pwm_out;
        end
      end
    end
  end

  task automatic do_load(input int p, input logic [CH*W-1:0] dv, input bit c);
    period      = W'(p);
    duty        = dv;
    center_mode = c;
    load        = 1'b1;
    @(negedge clk);
    load        = 1'b0;
  endtask

  task automatic wait_applied(input string tag, input int limit);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (!load_pending) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check(tag, ok, 1);
  endtask

  task automatic wait_pe(input string tag, input int limit);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (period_end) begin
        ok = 1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  task automatic expect_periods(input rec_t r, input int n);
    restart_req++;
    for (int i = 0; i < n; i++) sb.push_back(r);
  endtask

  task automatic drain(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check(tag, sb.size(), 0);
    sb.delete();
  endtask

  task automatic quiet_window(input string tag, input int n);
    int npe = 0;
    int nout = 0;
    for (int i = 0; i < n; i++) begin
      if (period_end) npe++;
      if (pwm_out != '0) nout++;
      @(negedge clk);
    end
    check({tag, "_pe"}, npe, 0);
    check({tag, "_out"}, nout, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    center_mode = 1'b0;
    period      = '0;
    duty        = '0;
    load        = 1'b0;
    polarity    = '0;
    repeat (3) @(negedge clk);
    check("rst_out", pwm_out, 0);
    check("rst_pe", period_end, 0);
    check("rst_pend", load_pending, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // Edge mode, three duties plus a zero duty.
    do_load(10000, pack(2500, 5000, 7500, 0), 0);
    wait_applied("t1_apply", 4);
    expect_periods(model(10000, pack(2500, 5000, 7500, 0), 0, 4'b0000), 1);
    drain("t1_drain", 21000);

    // Limits: duty equal to and far above period, then period 1, then period 0.
    do_load(200, pack(200, 65535, 0, 100), 0);
    check("t2_pend", load_pending, 1);
    wait_applied("t2_apply", 11000);
    expect_periods(model(200, pack(200, 65535, 0, 100), 0, 4'b0000), 2);
    drain("t2_drain", 700);

    do_load(1, pack(1, 0, 5, 0), 0);
    wait_applied("t2_p1_apply", 300);
    expect_periods(model(1, pack(1, 0, 5, 0), 0, 4'b0000), 3);
    drain("t2_p1_drain", 20);

    do_load(0, pack(5, 5, 5, 5), 0);
    wait_applied("t2_p0_apply", 4);
    repeat (2) @(negedge clk);
    quiet_window("t2_p0", 300);
    do_load(50, pack(10, 20, 30, 40), 0);
    check("t2_p0_direct", load_pending, 0);

    // Center mode.
    do_load(100, pack(25, 100, 0, 50), 1);
    wait_applied("t4_apply", 100);
    expect_periods(model(100, pack(25, 100, 0, 50), 1, 4'b0000), 2);
    drain("t4_drain", 500);

    // Mid-period reload; the last of two loads wins.
    do_load(1000, pack(250, 0, 0, 0), 0);
    wait_applied("t3_apply", 300);
    expect_periods(model(1000, pack(250, 0, 0, 0), 0, 4'b0000), 1);
    sb.push_back(model(1000, pack(700, 0, 0, 0), 0, 4'b0000));
    repeat (300) @(negedge clk);
    do_load(1000, pack(500, 0, 0, 0), 0);
    check("t3_pend1", load_pending, 1);
    repeat (100) @(negedge clk);
    do_load(1000, pack(700, 0, 0, 0), 0);
    check("t3_pend2", load_pending, 1);
    wait_pe("t3_pe", 1000);
    check("t3_pend_clr", load_pending, 0);
    drain("t3_drain", 1200);

    // Polarity, disable and re-enable.
    polarity = 4'b0001;
    do_load(1000, pack(250, 500, 0, 1000), 0);
    wait_applied("t5_apply", 1100);
    expect_periods(model(1000, pack(250, 500, 0, 1000), 0, 4'b0001), 1);
    drain("t5_drain", 1200);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("t5_dis_out", pwm_out, 4'b0001);
    check("t5_dis_pe", period_end, 0);
    do_load(1000, pack(100, 500, 0, 1000), 0);
    check("t5_dis_pend", load_pending, 0);
    repeat (10) @(negedge clk);
    check("t5_dis_hold", pwm_out, 4'b0001);
    enable = 1'b1;
    expect_periods(model(1000, pack(100, 500, 0, 1000), 0, 4'b0001), 1);
    @(negedge clk);
    check("t5_en_pe", period_end, 1);
    check("t5_en_ch0", pwm_out[0], 0);
    drain("t5_en_drain", 1200);

    // Asynchronous reset while an output is high and a load is pending.
    polarity = 4'b0000;
    do_load(1000, pack(500, 0, 0, 0), 0);
    wait_applied("t6_apply", 1100);
    wait_pe("t6_pe", 1100);
    repeat (10) @(negedge clk);
    do_load(1000, pack(900, 0, 0, 0), 0);
    check("t6_pre_ch0", pwm_out[0], 1);
    check("t6_pre_pend", load_pending, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_out", pwm_out, 0);
    check("t6_async_pend", load_pending, 0);
    check("t6_async_pe", period_end, 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_window("t6_post", 50);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
